rx_frame_fifo: RTL
==================

RX_FRAME_FIFO -- requirements
Module: rx_frame_fifo

Interface
REQ-001 SHALL have parameter CMD_W, default 8, command field width in bits.
REQ-002 SHALL have parameter ID_W, default 8, device-ID field width in bits.
REQ-003 SHALL have parameter DATA_W, default 32, data field width in bits.
REQ-004 SHALL have parameter TRL_W, default 5, zero-trailer width in bits.
REQ-005 SHALL have parameter HDR_ONES, default 5, number of consecutive 1s forming a header.
REQ-006 SHALL have parameter STUFF_RUN, default 4, body 1-run length after which one bit is discarded.
REQ-007 SHALL have parameter DEPTH, default 4 (power of 2, >=2), number of frame FIFO entries.
REQ-008 SHALL have parameter BCAST_EN, default 1; when 1, an all-ones ID is also accepted.
REQ-009 Ports SHALL be: clk in 1, rising-edge clock; clr in 1, asynchronous active-high reset.
REQ-010 Ports SHALL be: sd_in in 1, serial data sampled every clk; device_id in ID_W, own address.
REQ-011 Ports SHALL be: ack in 1, consumer acknowledge; err_clr in 1, clears sticky error flags.
REQ-012 Ports SHALL be: dout out CMD_W+DATA_W, FIFO head {cmd,data}; dav out 1, FIFO non-empty.
REQ-013 Ports SHALL be: fifo_cnt out $clog2(DEPTH)+1, occupancy; err_par, err_trl, err_ovf out 1 each, sticky flags.

Function
REQ-014 SHALL use one clock and a single asynchronous active-high reset clr, as already decided.
REQ-015 Frame body SHALL be FW=CMD_W+ID_W+DATA_W+1+TRL_W bits, LSB first: cmd, id, data, parity, trailer.
REQ-016 FSM SHALL have states HUNT, BODY and CHECK.
REQ-017 In HUNT, a run counter SHALL increment on sd_in=1, clear on sd_in=0, and move to BODY at the edge sampling the HDR_ONES-th consecutive 1.
REQ-018 In BODY, each non-stuffed sample SHALL be shifted into the frame register and the bit counter incremented.
REQ-019 In BODY, the sample following STUFF_RUN consecutive body 1s SHALL be discarded regardless of value, and the 1-run counter SHALL clear.
REQ-020 Stuffed bits SHALL NOT count toward FW, the 1-run counter SHALL clear on a kept 0, and the header counter SHALL be inactive in BODY.
REQ-021 The edge accepting the FW-th kept bit SHALL move to CHECK; CHECK SHALL last exactly one cycle, ignore sd_in, then return to HUNT with the header counter at 0.
REQ-022 In CHECK: id_ok = (id==device_id) or (BCAST_EN and id all ones); par_ok = even number of 1s over cmd, id, data and parity; trl_ok = trailer all zero.
REQ-023 At the CHECK exit edge, if id_ok, par_ok and trl_ok all hold, {cmd,data} SHALL be pushed into the FIFO.
REQ-024 A frame with id_ok=0 SHALL be dropped silently with no flag set.
REQ-025 A frame with id_ok=1 and par_ok=0 SHALL set err_par; one with id_ok=1 and trl_ok=0 SHALL set err_trl; neither SHALL be pushed.
REQ-026 A push while the FIFO is full with no pop in the same cycle SHALL drop the frame, set err_ovf, and leave FIFO contents unchanged.
REQ-027 ack SHALL be registered once (ack_q); a pop SHALL occur on the cycle where ack_q=1 and the previous ack_q=0, provided dav=1.
REQ-028 A held ack SHALL pop exactly one entry; a pop rising edge while dav=0 SHALL be ignored.
REQ-029 Simultaneous push and pop SHALL both take effect, with fifo_cnt unchanged; when full, this SHALL NOT set err_ovf.
REQ-030 dout SHALL be the registered FIFO head, valid whenever dav=1; dout SHALL be 0 when empty.
REQ-031 Pointers SHALL wrap modulo DEPTH; fifo_cnt SHALL range from 0 to DEPTH.
REQ-032 Sticky flags SHALL clear when err_clr=1; a set event in the same cycle as err_clr SHALL win, so the flag stays 1.
REQ-033 Latency: for an accepted frame into an empty FIFO, dav SHALL rise 2 edges after the edge sampling the last trailer bit.

Reset
REQ-034 On clr=1, state SHALL be HUNT, all counters 0, frame register 0, FIFO empty, ack_q 0, dout 0, dav 0, fifo_cnt 0, and all error flags 0.
REQ-035 clr asserted mid-frame SHALL abort the frame; after release, reception SHALL require a fresh header.

Verification
REQ-036 Defaults, device_id=8'h5A: header, then cmd=8'h01, id=8'h5A, data=32'h0000_0003, correct parity, trailer 0 -> dav=1 and dout=40'h01_0000_0003 at REQ-033 timing.
REQ-037 Same frame with id=8'h33 -> dav stays 0 and all error flags stay 0; with id=8'hFF -> accepted, and with BCAST_EN=0 -> dropped.
REQ-038 data=32'hFFFF_FFFF sent with a 0 stuffed after each four 1s -> dout=40'h01_FFFF_FFFF; the same frame sent without stuffing -> no push.
REQ-039 Flipped parity bit -> err_par=1 and no push; trailer 5'b00100 -> err_trl=1; err_clr pulse -> both return to 0.
REQ-040 Five accepted frames with no ack -> fifo_cnt=4 and err_ovf=1; then an ack held high for 10 cycles -> exactly one pop and fifo_cnt=3.
REQ-041 clr pulsed after 20 body bits, then a full valid frame -> exactly one entry; the aborted frame is never pushed.

Source files
------------

// File: rtl/rx_frame_fifo.sv
// -----------------------------------------------------------------------------
// rx_frame_fifo
//   Serial frame receiver with a small frame FIFO.
//   A header of HDR_ONES consecutive 1s starts a frame. The body is FW bits,
//   LSB first: cmd, id, data, parity, trailer. Inside the body, the sample
//   that follows STUFF_RUN consecutive 1s is a stuffed bit and is discarded.
//   Frames addressed to device_id (or broadcast, when enabled) with even
//   parity and an all-zero trailer push {cmd,data} into the FIFO. The
//   consumer pops one entry per rising edge of the registered ack.
//
// Ports
//   clk        in   rising-edge clock
//   clr        in   asynchronous active-high reset
//   sd_in      in   serial data, sampled every clk
//   device_id  in   own address (ID_W bits)
//   ack        in   consumer acknowledge (one pop per rising edge)
//   err_clr    in   clears the sticky error flags
//   dout       out  registered FIFO head {cmd,data}, 0 when empty
//   dav        out  FIFO non-empty
//   fifo_cnt   out  FIFO occupancy, 0..DEPTH
//   err_par    out  sticky: addressed frame with bad parity
//   err_trl    out  sticky: addressed frame with non-zero trailer
//   err_ovf    out  sticky: valid frame dropped because the FIFO was full
// -----------------------------------------------------------------------------
module rx_frame_fifo #(
    parameter int CMD_W     = 8,
    parameter int ID_W      = 8,
    parameter int DATA_W    = 32,
    parameter int TRL_W     = 5,
    parameter int HDR_ONES  = 5,
    parameter int STUFF_RUN = 4,
    parameter int DEPTH     = 4,
    parameter int BCAST_EN  = 1
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic                      sd_in,
    input  logic [ID_W-1:0]           device_id,
    input  logic                      ack,
    input  logic                      err_clr,
    output logic [CMD_W+DATA_W-1:0]   dout,
    output logic                      dav,
    output logic [$clog2(DEPTH):0]    fifo_cnt,
    output logic                      err_par,
    output logic                      err_trl,
    output logic                      err_ovf
);

    localparam int FW      = CMD_W + ID_W + DATA_W + 1 + TRL_W;
    localparam int OW      = CMD_W + DATA_W;
    localparam int PAR_POS = CMD_W + ID_W + DATA_W;
    localparam int PW      = $clog2(DEPTH);
    localparam int CW      = PW + 1;
    localparam int BCW     = $clog2(FW + 1);
    localparam int HCW     = $clog2(HDR_ONES + 1);
    localparam int RCW     = $clog2(STUFF_RUN + 1);

    localparam logic [BCW-1:0] BIT_LAST = BCW'(FW - 1);
    localparam logic [HCW-1:0] HDR_LAST = HCW'(HDR_ONES - 1);
    localparam logic [RCW-1:0] RUN_MAX  = RCW'(STUFF_RUN);
    localparam logic [CW-1:0]  CNT_FULL = CW'(DEPTH);

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_BODY  = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    // Odd-parity helper: 1 when the vector holds an odd number of 1s.
    function automatic logic calc_odd_par(input logic [PAR_POS:0] bits_s);
        return ^bits_s;
    endfunction

    state_t             state_r;
    logic [HCW-1:0]     hdr_cnt_r;
    logic [RCW-1:0]     run_cnt_r;
    logic [BCW-1:0]     bit_cnt_r;
    logic [FW-1:0]      frame_r;

    logic [OW-1:0]      mem_r [DEPTH];
    logic [PW-1:0]      wr_ptr_r;
    logic [PW-1:0]      rd_ptr_r;
    logic [CW-1:0]      cnt_r;

    logic               ack_q_r;
    logic               ack_q_d_r;
    logic               dav_r;
    logic [OW-1:0]      dout_r;
    logic               err_par_r;
    logic               err_trl_r;
    logic               err_ovf_r;

    logic [CMD_W-1:0]   cmd_s;
    logic [ID_W-1:0]    id_s;
    logic [DATA_W-1:0]  data_s;
    logic [TRL_W-1:0]   trl_s;
    logic               in_check_s;
    logic               id_ok_s;
    logic               par_ok_s;
    logic               trl_ok_s;
    logic               push_req_s;
    logic               full_s;
    logic               pop_s;
    logic               push_s;
    logic               ovf_s;
    logic               par_err_s;
    logic               trl_err_s;

    // Receive FSM: header hunt, de-stuffing body shift, one-cycle check.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_r   <= ST_HUNT;
            hdr_cnt_r <= HCW'(0);
            run_cnt_r <= RCW'(0);
            bit_cnt_r <= BCW'(0);
            frame_r   <= FW'(0);
        end else begin
            case (state_r)
                ST_HUNT: begin
                    if (sd_in) begin
                        if (hdr_cnt_r == HDR_LAST) begin
                            state_r   <= ST_BODY;
                            hdr_cnt_r <= HCW'(0);
                        end else begin
                            hdr_cnt_r <= hdr_cnt_r + 1'b1;
                        end
                    end else begin
                        hdr_cnt_r <= HCW'(0);
                    end
                end
                ST_BODY: begin
                    if (run_cnt_r == RUN_MAX) begin
                        // Stuffed sample: dropped whatever its value.
                        run_cnt_r <= RCW'(0);
                    end else begin
                        // LSB first: after FW shifts the first bit sits at bit 0.
                        frame_r   <= {sd_in, frame_r[FW-1:1]};
                        run_cnt_r <= sd_in ? (run_cnt_r + 1'b1) : RCW'(0);
                        if (bit_cnt_r == BIT_LAST) begin
                            state_r   <= ST_CHECK;
                            bit_cnt_r <= BCW'(0);
                            run_cnt_r <= RCW'(0);
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 1'b1;
                        end
                    end
                end
                ST_CHECK: begin
                    state_r   <= ST_HUNT;
                    hdr_cnt_r <= HCW'(0);
                end
                default: begin
                    state_r   <= ST_HUNT;
                    hdr_cnt_r <= HCW'(0);
                    run_cnt_r <= RCW'(0);
                    bit_cnt_r <= BCW'(0);
                end
            endcase
        end
    end

    // Frame field decode, acceptance checks and FIFO push/pop decisions.
    always_comb begin
        cmd_s      = frame_r[CMD_W-1:0];
        id_s       = frame_r[CMD_W +: ID_W];
        data_s     = frame_r[CMD_W+ID_W +: DATA_W];
        trl_s      = frame_r[FW-1 -: TRL_W];
        in_check_s = (state_r == ST_CHECK);
        id_ok_s    = (id_s == device_id) ||
                     ((BCAST_EN != 0) && (id_s == {ID_W{1'b1}}));
        par_ok_s   = ~calc_odd_par(frame_r[PAR_POS:0]);
        trl_ok_s   = (trl_s == {TRL_W{1'b0}});
        push_req_s = in_check_s & id_ok_s & par_ok_s & trl_ok_s;
        par_err_s  = in_check_s & id_ok_s & ~par_ok_s;
        trl_err_s  = in_check_s & id_ok_s & ~trl_ok_s;
        full_s     = (cnt_r == CNT_FULL);
        // Pop on the rising edge of the registered ack; a held ack pops once.
        pop_s      = ack_q_r & ~ack_q_d_r & dav_r & (cnt_r != CW'(0));
        // A pop in the same cycle frees the slot the push needs.
        push_s     = push_req_s & (~full_s | pop_s);
        ovf_s      = push_req_s & full_s & ~pop_s;
    end

    // FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= OW'(0);
            end
            wr_ptr_r <= PW'(0);
            rd_ptr_r <= PW'(0);
            cnt_r    <= CW'(0);
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= {cmd_s, data_s};
                wr_ptr_r        <= wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push_s, pop_s})
                2'b10:   cnt_r <= cnt_r + 1'b1;
                2'b01:   cnt_r <= cnt_r - 1'b1;
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Ack edge detection and registered head/valid outputs.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            ack_q_r   <= 1'b0;
            ack_q_d_r <= 1'b0;
            dav_r     <= 1'b0;
            dout_r    <= OW'(0);
        end else begin
            ack_q_r   <= ack;
            ack_q_d_r <= ack_q_r;
            dav_r     <= (cnt_r != CW'(0));
            dout_r    <= (cnt_r != CW'(0)) ? mem_r[rd_ptr_r] : OW'(0);
        end
    end

    // Sticky error flags; a set event outranks err_clr in the same cycle.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            err_par_r <= 1'b0;
            err_trl_r <= 1'b0;
            err_ovf_r <= 1'b0;
        end else begin
            err_par_r <= par_err_s ? 1'b1 : (err_clr ? 1'b0 : err_par_r);
            err_trl_r <= trl_err_s ? 1'b1 : (err_clr ? 1'b0 : err_trl_r);
            err_ovf_r <= ovf_s     ? 1'b1 : (err_clr ? 1'b0 : err_ovf_r);
        end
    end

    assign dout     = dout_r;
    assign dav      = dav_r;
    assign fifo_cnt = cnt_r;
    assign err_par  = err_par_r;
    assign err_trl  = err_trl_r;
    assign err_ovf  = err_ovf_r;

endmodule
